main_memory_model: RTL
======================

// Module: main_memory_model
// PURPOSE
//  Word-addressed backing store sitting directly downstream of cache_controller on its memory bus.
//  Serves the cache's line fill (read) and write-back (write) requests with a fixed, parameterised latency.
//  Port names match the cache controller's memory-side nets, so top-level wiring is name-for-name:
//  MEM_DATAOUT is write data into this block; MEM_DATAIN is read data out of it.
// PARAMETERS
//  ADDR_W      32  request address width
//  DATA_W      65  data word width, same as cache data bus
//  DEPTH_LOG2  12  log2 of word count; index = MEM_ADDRESS[DEPTH_LOG2-1:0]
//  LATENCY     3   busy cycles per request, legal range 1..255
// PORTS
//  clock        in   1       single clock, all logic on posedge
//  rst          in   1       synchronous, active-high reset
//  MEM_ADDRESS  in   ADDR_W  request word address
//  MEM_DATAOUT  in   DATA_W  write data from cache
//  MEM_DATAIN   out  DATA_W  read data to cache
//  mem_rw       in   1       1=write, 0=read
//  mem_val      in   1       request valid
//  mem_ready    out  1       1=idle/complete, 0=busy
//  mem_err      out  1       out-of-range flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, mem_ready=1, MEM_DATAIN=0, mem_err=0, latency counter=0.
//   Storage array is not cleared.
//  States:
//   IDLE: mem_ready=1.
//    If mem_val=1, latch MEM_ADDRESS, mem_rw and MEM_DATAOUT, load cnt=LATENCY-1,
//    drop mem_ready at the next edge, then go to BUSY.
//   BUSY: mem_ready=0. Inputs are ignored; the latched copies are used.
//    cnt decrements each cycle. At cnt==0 go to DONE.
//   DONE: one cycle, mem_ready=1.
//    Read: MEM_DATAIN = mem[idx], registered and valid from this cycle.
//    Write: mem[idx] <= latched data, committed on the DONE edge.
//    Then go to RELEASE.
//   RELEASE: mem_ready=1. Stay until mem_val=0 is sampled, then go to IDLE.
//    This prevents a held mem_val from being re-accepted.
//  Latency: mem_ready is low for exactly LATENCY cycles per accepted request.
//  MEM_DATAIN holds the last read data until the next read completes; writes leave it unchanged.
//  Write-then-read to the same index returns the new data (commit happens before the read is accepted).
//  rst during BUSY aborts the request; a pending write is NOT committed; mem_ready=1 on the next cycle.
//  mem_val=1 on the same edge as rst: reset wins and the request is dropped.
//  Index wrap: address bits above DEPTH_LOG2 are ignored unless the macro below is defined.
// CONFIGURATION
//  MAIN_MEM_RANGE_CHECK_EN defined:
//   A request with MEM_ADDRESS[ADDR_W-1:DEPTH_LOG2]!=0 still takes LATENCY cycles.
//   At DONE: mem_err=1 for that one cycle, the write is suppressed, and a read returns MEM_DATAIN=0.
//  Undefined:
//   mem_err is tied 0 and addresses alias modulo 2^DEPTH_LOG2.
// TESTING (defaults, LATENCY=3)
//  1. Reset -> mem_ready=1, MEM_DATAIN=0, mem_err=0 on the first cycle after rst falls.
//  2. Write 0xB00 data 0x122, then read 0xB00 -> mem_ready low exactly 3 cycles each; read returns 0x122.
//  3. Hold mem_val=1 across a read of 0xB00 -> exactly one accept; no re-accept until mem_val is low for 1 cycle.
//  4. Write 0x344 to 0xC00, assert rst during the 2nd BUSY cycle, then read 0xC00 -> old contents; 0x344 is not present.
//  5. Macro on: write 0x66 to 0xEB00 -> mem_err=1 for 1 cycle; read 0x0B00 is unchanged.
//     Macro off: the same write lands at idx 0xB00.
//  6. Back-to-back writes 0xB00=0x1, 0xB00=0x2, then read -> returns 0x2; MEM_DATAIN is unchanged during the writes.

Source files
------------

// File: rtl/main_memory_model.sv
// Word-addressed backing store for the cache memory bus; every request takes LATENCY busy cycles.
// Optional out-of-range detection is built when MAIN_MEM_RANGE_CHECK_EN is defined.
module main_memory_model #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 65,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 3
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [ADDR_W-1:0] MEM_ADDRESS,
  input  logic [DATA_W-1:0] MEM_DATAOUT,
  output logic [DATA_W-1:0] MEM_DATAIN,
  input  logic              mem_rw,
  input  logic              mem_val,
  output logic              mem_ready,
  output logic              mem_err,
  output logic [1:0]        fsm_state
);

  // Handshake: a request is taken when mem_val=1 is sampled in IDLE; mem_ready stays low
  // for LATENCY cycles, rises with the result, and mem_val must drop before the next accept.
  typedef enum logic [1:0] {IDLE, BUSY, DONE, RELEASE} state_t;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_t            state, state_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rw_q;
  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] idx;
  logic              out_of_range;
  logic              finish;

  assign idx    = addr_q[DEPTH_LOG2-1:0];
  assign finish = (state == BUSY) && (cnt == 8'd0);

`ifdef MAIN_MEM_RANGE_CHECK_EN
  assign out_of_range = (addr_q[ADDR_W-1:DEPTH_LOG2] != '0);
`else
  // Upper address bits are ignored so indices alias modulo the array depth.
  logic addr_hi_unused;
  assign addr_hi_unused = |addr_q[ADDR_W-1:DEPTH_LOG2];
  assign out_of_range   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_val) begin
          state_nxt = BUSY;
          cnt_nxt   = LAT_M1;
        end
      end
      BUSY: begin
        if (cnt == 8'd0) state_nxt = DONE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      DONE:    state_nxt = RELEASE;
      RELEASE: if (!mem_val) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      MEM_DATAIN <= '0;
      mem_err    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_err <= finish && out_of_range;
      if (finish && !rw_q) MEM_DATAIN <= out_of_range ? '0 : mem[idx];
    end
  end

  // Request capture; a request coinciding with reset is dropped.
  always_ff @(posedge clock) begin
    if (!rst && state == IDLE && mem_val) begin
      addr_q  <= MEM_ADDRESS;
      wdata_q <= MEM_DATAOUT;
      rw_q    <= mem_rw;
    end
  end

  // Storage is never cleared; a reset while busy skips the pending commit.
  always_ff @(posedge clock) begin
    if (!rst && finish && rw_q && !out_of_range) mem[idx] <= wdata_q;
  end

  assign mem_ready = (state != BUSY);
  assign fsm_state = state;

endmodule
